fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the RV32I core.

---
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID register and one-entry skid buffer.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall event counters.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           OP_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PCSrcE,
    input  logic [ADDR_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_valid,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [OP_WIDTH-1:0]   OpD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
`ifdef FETCH_PERF_EN
   ,output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   pcf, pcf_next, pcf_plus4;
    logic [DATA_WIDTH-1:0]   skid_instr, skid_instr_next;
    logic [ADDR_WIDTH-1:0]   skid_pc, skid_pc_next;

    logic                    ifid_we;
    logic [DATA_WIDTH-1:0]   ifid_instr;
    logic [ADDR_WIDTH-1:0]   ifid_pc, ifid_pc4;
    logic                    ifid_valid;

    logic                    unused_tgt_lsbs;

    assign unused_tgt_lsbs = ^PCTargetE[1:0];
    assign pcf_plus4       = pcf + ADDR_WIDTH'(4);
    assign imem_addr       = pcf;
    assign OpD             = InstrD[OP_WIDTH-1:0];

    always_comb begin
        state_next      = state;
        pcf_next        = pcf;
        skid_instr_next = skid_instr;
        skid_pc_next    = skid_pc;
        imem_req        = 1'b0;
        ifid_we         = 1'b0;
        ifid_instr      = NOP;
        ifid_pc         = '0;
        ifid_pc4        = '0;
        ifid_valid      = 1'b0;

        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid && !StallF)
                    pcf_next = pcf_plus4;
                if (FlushD) begin
                    ifid_we = 1'b1;
                end else if (imem_valid && !StallD) begin
                    ifid_we    = 1'b1;
                    ifid_instr = imem_rdata;
                    ifid_pc    = pcf;
                    ifid_pc4   = pcf_plus4;
                    ifid_valid = 1'b1;
                end else if (imem_valid) begin
                    skid_instr_next = imem_rdata;
                    skid_pc_next    = pcf;
                    state_next      = HOLD;
                end else if (!StallD) begin
                    ifid_we = 1'b1;
                end
            end
            HOLD: begin
                if (FlushD) begin
                    ifid_we         = 1'b1;
                    skid_instr_next = '0;
                    skid_pc_next    = '0;
                    state_next      = FETCH;
                end else if (!StallD) begin
                    ifid_we         = 1'b1;
                    ifid_instr      = skid_instr;
                    ifid_pc         = skid_pc;
                    ifid_pc4        = skid_pc + ADDR_WIDTH'(4);
                    ifid_valid      = 1'b1;
                    skid_instr_next = '0;
                    skid_pc_next    = '0;
                    // Resume after the parked word so a capture taken under StallF is not refetched.
                    pcf_next        = skid_pc + ADDR_WIDTH'(4);
                    state_next      = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase

        // Redirect dominates: drop the returned word and any parked word.
        if (PCSrcE) begin
            pcf_next        = {PCTargetE[ADDR_WIDTH-1:2], 2'b00};
            skid_instr_next = '0;
            skid_pc_next    = '0;
            state_next      = FETCH;
            ifid_we         = FlushD || !StallD;
            ifid_instr      = NOP;
            ifid_pc         = '0;
            ifid_pc4        = '0;
            ifid_valid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pcf        <= RESET_PC;
            skid_instr <= '0;
            skid_pc    <= '0;
            InstrD     <= NOP;
            PCD        <= '0;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
        end else begin
            state      <= state_next;
            pcf        <= pcf_next;
            skid_instr <= skid_instr_next;
            skid_pc    <= skid_pc_next;
            if (ifid_we) begin
                InstrD   <= ifid_instr;
                PCD      <= ifid_pc;
                PCPlus4D <= ifid_pc4;
                ValidD   <= ifid_valid;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (ifid_we && ifid_valid)
                perf_fetched <= perf_fetched + 32'd1;
            if (StallD)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process queues expected IF/ID
// contents, a monitor pops one entry per freshly loaded valid instruction.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] InstrD;
    logic [6:0]  OpD;
    logic [31:0] PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        ovr_en   = 1'b0;
    logic [31:0] ovr_data = '0;

    fetch_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .OP_WIDTH  (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .InstrD    (InstrD),
        .OpD       (OpD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
       ,.perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[24:0], 7'b0110011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.pc4   = pc4;
        sb.push_back(e);
    endtask

    // Apply one cycle of inputs just after an edge, then advance to 1 ns past the next edge.
    task automatic tick(input logic v, input logic sf, input logic sd, input logic fd,
                        input logic pcs, input logic [31:0] tgt);
        StallF     = sf;
        StallD     = sd;
        FlushD     = fd;
        PCSrcE     = pcs;
        PCTargetE  = tgt;
        imem_valid = v & imem_req;
        imem_rdata = ovr_en ? ovr_data : word(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},    {31'b0, imem_req}, 32'd0);
        check({tag, "_addr"},   imem_addr,         32'h0000_0000);
        check({tag, "_instr"},  InstrD,            32'h0000_0013);
        check({tag, "_op"},     {25'b0, OpD},      32'h0000_0013);
        check({tag, "_pcd"},    PCD,               32'd0);
        check({tag, "_pc4d"},   PCPlus4D,          32'd0);
        check({tag, "_validd"}, {31'b0, ValidD},   32'd0);
    endtask

    // A new valid IF/ID entry can only appear after an edge where StallD was low.
    always @(posedge clk) begin
        logic sd_edge;
        exp_t e;
        sd_edge = StallD;
        @(negedge clk);
        if (rst_n && ValidD && !sd_edge) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got instr %h pc %h, expected none", InstrD, PCD);
            end else begin
                e = sb.pop_front();
                check("sb_instr", InstrD,         e.instr);
                check("sb_pcd",   PCD,            e.pc);
                check("sb_pc4d",  PCPlus4D,       e.pc4);
                check("sb_opd",   {25'b0, OpD},   {25'b0, e.instr[6:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        PCSrcE     = 1'b0;
        PCTargetE  = '0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;

        check("boot_req", {31'b0, imem_req}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("fetch_req",  {31'b0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, 32'h0);

        for (int unsigned i = 0; i < 3; i++) begin
            push(word(4 * i), 4 * i, 4 * i + 4);
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            check("seq_addr", imem_addr, 4 * i + 4);
        end

        ovr_en   = 1'b1;
        ovr_data = 32'h00A0_0093;
        for (int unsigned i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
            check("hold_req",   {31'b0, imem_req}, 32'd0);
            check("hold_instr", InstrD, word(32'd8));
        end
        ovr_en = 1'b0;
        push(32'h00A0_0093, 32'd12, 32'd16);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("release_instr", InstrD,            32'h00A0_0093);
        check("release_addr",  imem_addr,         32'd16);
        check("release_req",   {31'b0, imem_req}, 32'd1);
        push(word(32'd16), 32'd16, 32'd20);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("post_release_addr", imem_addr, 32'd20);

        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("stalld_req", {31'b0, imem_req}, 32'd0);
        push(word(32'd20), 32'd20, 32'd24);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("stalld_addr", imem_addr, 32'd24);

        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        check("redir_addr",   imem_addr,         32'h0000_0100);
        check("redir_validd", {31'b0, ValidD},   32'd0);
        check("redir_instr",  InstrD,            32'h0000_0013);
        check("redir_op",     {25'b0, OpD},      32'h0000_0013);
        push(word(32'h100), 32'h100, 32'h104);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("target_addr", imem_addr, 32'h104);

        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("bubble_validd", {31'b0, ValidD}, 32'd0);
        check("bubble_addr",   imem_addr,       32'h104);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("flush_validd", {31'b0, ValidD}, 32'd0);
        check("flush_addr",   imem_addr,       32'h108);

        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        check("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
        push(word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4d", PCPlus4D,  32'h0);

        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("pre_rst_hold_req", {31'b0, imem_req}, 32'd0);
        #2;
        rst_n      = 1'b0;
        StallD     = 1'b0;
        imem_valid = 1'b0;
        #1;
        check_reset_values("midhold_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rerst_boot_req", {31'b0, imem_req}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("rerst_addr", imem_addr, 32'h0);

        for (int unsigned i = 0; i < 5; i++) begin
            push(word(4 * i), 4 * i, 4 * i + 4);
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        end
        check("rerst_seq_addr", imem_addr, 32'd20);
        repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_stall",   perf_stall,   32'd2);
`endif
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("sb_drain", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
